time_entry_loader: RTL and testbench

TIME_ENTRY_LOADER -- requirements
Module: time_entry_loader

---
 rtl/time_entry_loader_pkg.sv | 15 +
 rtl/time_entry_loader_bcd_entry_shifter.sv | 43 ++++
 rtl/time_entry_loader.sv | 112 +++++++++++
 tb/tb_time_entry_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/time_entry_loader_pkg.sv
// Shared timer constants: FSM encoding, default digit capacity and seconds-tens limit.
package time_entry_loader_pkg;

    localparam int MAX_DIGITS = 4;

    localparam logic [3:0] SEC_TENS_LIMIT = 4'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/time_entry_loader_bcd_entry_shifter.sv
// BCD keypad shift register with digit count and seconds-tens saturation.
// Latency: one clock per shift/clear/saturate command.
// No backpressure; the controller gates every command.
module bcd_entry_shifter #(
    parameter int MAX_DIGITS = time_entry_loader_pkg::MAX_DIGITS
) (
    input  logic        clock,
    input  logic        clearn,
    input  logic        clear,
    input  logic        shift,
    input  logic        restart,
    input  logic        saturate,
    input  logic [3:0]  key_digit,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic        room
);
    import time_entry_loader_pkg::*;

    assign room = (count < 3'(MAX_DIGITS));

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            digits <= 16'h0000;
            count  <= 3'd0;
        end else if (clear) begin
            digits <= 16'h0000;
            count  <= 3'd0;
        end else if (shift) begin
            // restart begins a fresh entry after a finished cook
            if (restart) begin
                digits <= {12'h000, key_digit};
                count  <= 3'd1;
            end else begin
                digits <= {digits[11:0], key_digit};
                count  <= count + 3'd1;
            end
        end else if (saturate && (digits[7:4] > SEC_TENS_LIMIT)) begin
            digits[7:4] <= SEC_TENS_LIMIT;
        end
    end

endmodule

// File: rtl/time_entry_loader.sv
// Keypad time entry and cook-cycle controller driving downstream BCD timer counters.
// Latency: start -> LOAD (loadn low one cycle) -> RUN with timer_enable high.
// No backpressure; strobes are one-cycle, priority stop_clear > start > key_valid.
module time_entry_loader #(
    parameter int MAX_DIGITS = time_entry_loader_pkg::MAX_DIGITS
) (
    input  logic        clock,
    input  logic        clearn,
    input  logic [3:0]  key_digit,
    input  logic        key_valid,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_closed,
    input  logic        timer_zero,
    output logic [15:0] load_digits,
    output logic        loadn,
    output logic        timer_enable,
    output logic [2:0]  entry_count,
    output logic        done
);
    import time_entry_loader_pkg::*;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       key_ok;
    logic       room;
    logic       clr;
    logic       shift;
    logic       restart;
    logic       saturate;

    assign key_ok = key_valid && (key_digit <= 4'd9);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift     = 1'b0;
        restart   = 1'b0;
        saturate  = 1'b0;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (stop_clear) begin
                    clr       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    if ((state == ST_ENTRY) && door_closed && (load_digits != 16'h0000)) begin
                        saturate  = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end else if (key_ok && room) begin
                    shift     = 1'b1;
                    state_nxt = ST_ENTRY;
                end
            end
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                // expiry wins over a simultaneous pause request
                if (timer_zero)
                    state_nxt = ST_DONE;
                else if (stop_clear || !door_closed)
                    state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    clr       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (start && door_closed) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop_clear) begin
                    clr       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!start && key_ok) begin
                    shift     = 1'b1;
                    restart   = 1'b1;
                    state_nxt = ST_ENTRY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Moore decode so async reset drops every strobe without waiting for a clock
    assign loadn        = (state != ST_LOAD);
    assign timer_enable = (state == ST_RUN);
    assign done         = (state == ST_DONE);

    bcd_entry_shifter #(
        .MAX_DIGITS(MAX_DIGITS)
    ) u_shifter (
        .clock     (clock),
        .clearn    (clearn),
        .clear     (clr),
        .shift     (shift),
        .restart   (restart),
        .saturate  (saturate),
        .key_digit (key_digit),
        .digits    (load_digits),
        .count     (entry_count),
        .room      (room)
    );

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed self-checking bench for time_entry_loader.
module tb_time_entry_loader;

    logic        clock = 1'b0;
    logic        clearn;
    logic [3:0]  key_digit;
    logic        key_valid;
    logic        start;
    logic        stop_clear;
    logic        door_closed;
    logic        timer_zero;
    logic [15:0] load_digits;
    logic        loadn;
    logic        timer_enable;
    logic [2:0]  entry_count;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    time_entry_loader #(.MAX_DIGITS(4)) dut (
        .clock        (clock),
        .clearn       (clearn),
        .key_digit    (key_digit),
        .key_valid    (key_valid),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .load_digits  (load_digits),
        .loadn        (loadn),
        .timer_enable (timer_enable),
        .entry_count  (entry_count),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_clear = 1'b1;
        tick();
        stop_clear = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] dig, input logic ld_n,
                              input logic en, input logic [2:0] cnt, input logic dn);
        check({tag, ".digits"}, load_digits, dig);
        check({tag, ".loadn"}, 16'(loadn), 16'(ld_n));
        check({tag, ".enable"}, 16'(timer_enable), 16'(en));
        check({tag, ".count"}, 16'(entry_count), 16'(cnt));
        check({tag, ".done"}, 16'(done), 16'(dn));
    endtask

    initial begin
        clearn      = 1'b0;
        key_digit   = 4'h0;
        key_valid   = 1'b0;
        start       = 1'b0;
        stop_clear  = 1'b0;
        door_closed = 1'b1;
        timer_zero  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
        clearn = 1'b1;
        tick();

        // entry 1,3,0 then start: one-cycle load pulse, then enable
        press(4'd1); press(4'd3); press(4'd0);
        check_outs("entry130", 16'h0130, 1'b1, 1'b0, 3'd3, 1'b0);
        pulse_start();
        check_outs("load130", 16'h0130, 1'b0, 1'b0, 3'd3, 1'b0);
        tick();
        check_outs("run130", 16'h0130, 1'b1, 1'b1, 3'd3, 1'b0);

        // expiry coinciding with door opening lands in DONE
        timer_zero = 1'b1; door_closed = 1'b0;
        tick();
        timer_zero = 1'b0; door_closed = 1'b1;
        check_outs("zero_door", 16'h0130, 1'b1, 1'b0, 3'd3, 1'b1);
        tick();
        check("done_hold", 16'(done), 16'h1);
        press(4'd7);
        check_outs("key7", 16'h0007, 1'b1, 1'b0, 3'd1, 1'b0);

        // 9,9 saturates seconds tens to 5
        pulse_stop();
        check_outs("clear1", 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
        press(4'd9); press(4'd9);
        check("entry99", load_digits, 16'h0099);
        pulse_start();
        check_outs("load59", 16'h0059, 1'b0, 1'b0, 3'd2, 1'b0);
        tick();
        check("run59.enable", 16'(timer_enable), 16'h1);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        check("done59", 16'(done), 16'h1);

        // four digits fill the entry, fifth is dropped
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check_outs("entry1234", 16'h1234, 1'b1, 1'b0, 3'd4, 1'b0);
        press(4'd5);
        check_outs("fifth_key", 16'h1234, 1'b1, 1'b0, 3'd4, 1'b0);

        // door-open pause, resume without reload, double stop clears
        pulse_stop();
        press(4'd2);
        pulse_start();
        check("load2.loadn", 16'(loadn), 16'h0);
        tick();
        check("run2.enable", 16'(timer_enable), 16'h1);
        door_closed = 1'b0;
        tick();
        check_outs("pause_door", 16'h0002, 1'b1, 1'b0, 3'd1, 1'b0);
        door_closed = 1'b1;
        pulse_start();
        check_outs("resume", 16'h0002, 1'b1, 1'b1, 3'd1, 1'b0);
        pulse_stop();
        check("pause_stop.enable", 16'(timer_enable), 16'h0);
        pulse_stop();
        check_outs("second_stop", 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);

        // start ignored for zero entry and open door; out-of-range key ignored
        press(4'd0);
        check("entry0.count", 16'(entry_count), 16'h1);
        pulse_start();
        check_outs("start_zero", 16'h0000, 1'b1, 1'b0, 3'd1, 1'b0);
        press(4'd5);
        check_outs("entry05", 16'h0005, 1'b1, 1'b0, 3'd2, 1'b0);
        door_closed = 1'b0;
        pulse_start();
        check_outs("start_open", 16'h0005, 1'b1, 1'b0, 3'd2, 1'b0);
        press(4'hA);
        check_outs("key_A", 16'h0005, 1'b1, 1'b0, 3'd2, 1'b0);
        door_closed = 1'b1;
        pulse_start();
        check("load05.loadn", 16'(loadn), 16'h0);
        tick();
        check("run05.enable", 16'(timer_enable), 16'h1);

        // asynchronous reset mid-cycle during RUN
        #2;
        clearn = 1'b0;
        #1;
        check_outs("async_rst", 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        clearn = 1'b1;
        tick();
        check_outs("post_rst", 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
